// File: rtl/gpu_blit_engine.sv
// Framebuffer blit engine: register-programmed copy or fill from the back
// buffer into the front buffer, with optional vblank gating and abort.
module gpu_blit_engine #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 1200
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  bus_sel,
  input  logic [2:0]            bus_reg,
  input  logic                  bus_write,
  input  logic                  bus_read,
  input  logic [DATA_WIDTH-1:0] bus_wr_data,
  output logic [DATA_WIDTH-1:0] bus_rd_data,
  input  logic                  vblank,
  output logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0] src_rd_data,
  output logic [ADDR_WIDTH-1:0] dst_addr,
  output logic [DATA_WIDTH-1:0] dst_wr_data,
  output logic                  dst_we,
  output logic                  busy
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam int SW = ADDR_WIDTH + 2;
  localparam logic [LW-1:0] ONE   = LW'(1);
  localparam logic [SW-1:0] LIMIT = SW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RUN, DRAIN} state_t;

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] start_q;
  logic [LW-1:0]         length_q;
  logic [LW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] fill_q;
  logic                  wait_vb_q;
  logic                  done_q;
  logic                  error_q;
  logic                  aborted_q;
  logic                  fill_mode_q;
  logic                  pipe_valid_q;
  logic [ADDR_WIDTH-1:0] pipe_addr_q;
  logic [DATA_WIDTH-1:0] pipe_fill_q;

  logic          wr, idle;
  logic          ctrl_wr, start_wr, len_wr, fill_wr, status_wr;
  logic          go_req, bad, go_ok, abort;
  logic          paused, last, issue;
  logic [SW-1:0] end_sum;
  logic          done_set, clr_done, clr_err, clr_abt;

  assign wr        = bus_sel & bus_write;
  assign idle      = (state == IDLE);
  assign ctrl_wr   = wr & (bus_reg == 3'd0);
  assign start_wr  = wr & (bus_reg == 3'd1);
  assign len_wr    = wr & (bus_reg == 3'd2);
  assign fill_wr   = wr & (bus_reg == 3'd3);
  assign status_wr = wr & (bus_reg == 3'd4);

  // Range check is one bit wider than the sum so it cannot wrap.
  assign end_sum = {2'b00, start_q} + {1'b0, length_q};
  assign go_req  = ctrl_wr & idle & (bus_wr_data[0] | bus_wr_data[1]);
  assign bad     = (bus_wr_data[0] & bus_wr_data[1])
                 | (length_q == '0)
                 | (end_sum > LIMIT);
  assign go_ok   = go_req & ~bad;
  assign abort   = ctrl_wr & bus_wr_data[3] & ~idle;

  assign paused  = wait_vb_q & ~vblank;
  assign last    = (idx_q + ONE) == length_q;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    unique case (state)
      IDLE: begin
        if (go_ok) state_n = bus_wr_data[2] ? WAIT : RUN;
      end
      WAIT: begin
        if (abort)       state_n = IDLE;
        else if (vblank) state_n = RUN;
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (!paused) begin
          issue = 1'b1;
          if (last) state_n = DRAIN;
        end else if (!pipe_valid_q) begin
          state_n = WAIT;
        end
      end
      DRAIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A status set in the same cycle as a W1C clear takes priority.
  assign done_set = (state == DRAIN) & ~abort;
  assign clr_done = go_req | (status_wr & bus_wr_data[1]);
  assign clr_err  = go_req | (status_wr & bus_wr_data[2]);
  assign clr_abt  = go_req | (status_wr & bus_wr_data[3]);

  always_ff @(posedge clock) begin
    if (reset) begin
      start_q      <= '0;
      length_q     <= '0;
      fill_q       <= '0;
      wait_vb_q    <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      aborted_q    <= 1'b0;
      fill_mode_q  <= 1'b0;
      idx_q        <= '0;
      pipe_valid_q <= 1'b0;
      pipe_addr_q  <= '0;
      pipe_fill_q  <= '0;
    end else begin
      pipe_valid_q <= issue;
      if (issue) begin
        pipe_addr_q <= src_addr;
        pipe_fill_q <= fill_q;
        idx_q       <= idx_q + ONE;
      end
      if (go_ok) begin
        idx_q       <= '0;
        fill_mode_q <= bus_wr_data[1];
      end
      if (idle) begin
        if (start_wr) start_q   <= bus_wr_data[ADDR_WIDTH-1:0];
        if (len_wr)   length_q  <= bus_wr_data[LW-1:0];
        if (fill_wr)  fill_q    <= bus_wr_data;
        if (ctrl_wr)  wait_vb_q <= bus_wr_data[2];
      end
      done_q    <= done_set | (done_q & ~clr_done);
      error_q   <= (go_req & bad) | (error_q & ~clr_err);
      aborted_q <= abort | (aborted_q & ~clr_abt);
    end
  end

  assign src_addr    = start_q + idx_q[ADDR_WIDTH-1:0];
  assign dst_addr    = pipe_addr_q;
  assign dst_we      = pipe_valid_q;
  assign dst_wr_data = !pipe_valid_q ? '0
                     : fill_mode_q   ? pipe_fill_q
                     : src_rd_data;
  assign busy        = ~idle;

  always_comb begin
    bus_rd_data = '0;
    if (bus_sel & bus_read) begin
      case (bus_reg)
        3'd0: bus_rd_data[2] = wait_vb_q;
        3'd1: bus_rd_data[ADDR_WIDTH-1:0] = start_q;
        3'd2: bus_rd_data[LW-1:0] = length_q;
        3'd3: bus_rd_data = fill_q;
        3'd4: bus_rd_data[3:0] = {aborted_q, error_q, done_q, busy};
        default: bus_rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_blit_engine.sv
// Bench for gpu_blit_engine: directed scenarios plus randomized transfers
// compared against a word-list model of the expected front-buffer writes.
module tb_gpu_blit_engine;

  localparam int DW    = 64;
  localparam int AW    = 11;
  localparam int DEPTH = 1200;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          bus_sel = 1'b0;
  logic [2:0]    bus_reg = '0;
  logic          bus_write = 1'b0;
  logic          bus_read = 1'b0;
  logic [DW-1:0] bus_wr_data = '0;
  logic [DW-1:0] bus_rd_data;
  logic          vblank = 1'b0;
  logic [AW-1:0] src_addr;
  logic [DW-1:0] src_rd_data = '0;
  logic [AW-1:0] dst_addr;
  logic [DW-1:0] dst_wr_data;
  logic          dst_we;
  logic          busy;

  gpu_blit_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .bus_sel(bus_sel), .bus_reg(bus_reg),
    .bus_write(bus_write), .bus_read(bus_read),
    .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .vblank(vblank),
    .src_addr(src_addr), .src_rd_data(src_rd_data),
    .dst_addr(dst_addr), .dst_wr_data(dst_wr_data),
    .dst_we(dst_we), .busy(busy)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] back_mem [0:2047];
  always @(posedge clock) src_rd_data <= back_mem[src_addr];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  int            wc[$];
  bit            wv[$];
  logic          vb_last = 1'b0;

  always @(negedge clock) begin
    if (dst_we === 1'b1) begin
      wa.push_back(dst_addr);
      wd.push_back(dst_wr_data);
      wc.push_back(cyc);
      wv.push_back(vb_last);
    end
    vb_last = vblank;
  end

  int checks = 0;
  int errors = 0;
  int tw;
  logic [AW-1:0] exp_a[$];
  logic [DW-1:0] exp_d[$];

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic reg_wr(input logic [2:0] r, input logic [DW-1:0] d);
    bus_sel = 1'b1; bus_write = 1'b1; bus_reg = r; bus_wr_data = d;
    @(posedge clock); #1;
    bus_sel = 1'b0; bus_write = 1'b0; bus_wr_data = '0;
    tw = cyc;
  endtask

  task automatic reg_rd(input logic [2:0] r, output logic [DW-1:0] d);
    @(negedge clock);
    bus_sel = 1'b1; bus_read = 1'b1; bus_reg = r;
    #1 d = bus_rd_data;
    bus_sel = 1'b0; bus_read = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete(); wv.delete();
  endtask

  // Expected write list: one word per address of the range, ascending.
  function automatic void model(int s, int l, bit m, logic [DW-1:0] f);
    exp_a.delete(); exp_d.delete();
    for (int k = s; k < s + l; k++) begin
      exp_a.push_back(AW'(k));
      exp_d.push_back(m ? f : back_mem[k]);
    end
  endfunction

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin tick(); n++; end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s_timeout: busy still %b after %0d cycles, want 0",
               name, busy, budget);
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] rd;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checks++;
    if ({dst_we, busy, dst_addr, src_addr, dst_wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b busy=%b da=%0h sa=%0h wd=%0h, want 0",
               dst_we, busy, dst_addr, src_addr, dst_wr_data);
    end
    for (int r = 0; r < 5; r++) begin
      reg_rd(3'(r), rd);
      checks++;
      if (rd !== '0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %0h want 0", r, rd);
      end
    end
  endtask

  task automatic test_copy();
    int t0, nb;
    logic [DW-1:0] rd;
    for (int k = 0; k < 2048; k++) back_mem[k] = DW'(k + 'h100);
    reg_wr(1, 10);
    reg_wr(2, 5);
    clear_log();
    reg_wr(0, 1);
    t0 = tw;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL copy_busy_t1: got %b want 1", busy);
    end
    while (cyc < t0 + 5) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL copy_busy_last: got %b want 1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL copy_busy_end: got %b want 0", busy);
    end
    model(10, 5, 1'b0, '0);
    nb = 0;
    foreach (exp_a[j])
      if (j >= wa.size() || wa[j] !== exp_a[j] || wd[j] !== exp_d[j] ||
          wc[j] != t0 + 1 + j) nb++;
    checks++;
    if (wa.size() != exp_a.size() || nb != 0) begin
      errors++;
      $display("FAIL copy_writes: %0d writes %0d bad, want %0d writes 0 bad",
               wa.size(), nb, exp_a.size());
    end
    reg_rd(4, rd);
    checks++;
    if (rd !== 64'h2) begin
      errors++; $display("FAIL copy_status: got %0h want 2", rd);
    end
  endtask

  task automatic test_w1c();
    int t0;
    logic [DW-1:0] rd;
    reg_wr(1, 20);
    reg_wr(2, 3);
    reg_wr(0, 1);
    t0 = tw;
    while (cyc < t0 + 3) tick();
    reg_wr(4, 64'h2);
    reg_rd(4, rd);
    checks++;
    if (rd !== 64'h2) begin
      errors++; $display("FAIL w1c_set_wins: got %0h want 2", rd);
    end
    reg_wr(4, 64'hE);
    reg_rd(4, rd);
    checks++;
    if (rd !== 64'h0) begin
      errors++; $display("FAIL w1c_clear: got %0h want 0", rd);
    end
  endtask

  task automatic test_fill();
    int nb;
    logic [DW-1:0] rd;
    reg_wr(3, 64'hDEAD);
    reg_wr(1, 0);
    reg_wr(2, DEPTH);
    clear_log();
    reg_wr(0, 2);
    wait_idle(3000, "fill");
    model(0, DEPTH, 1'b1, 64'hDEAD);
    nb = 0;
    foreach (exp_a[j])
      if (j >= wa.size() || wa[j] !== exp_a[j] || wd[j] !== exp_d[j]) nb++;
    checks++;
    if (wa.size() != exp_a.size() || nb != 0) begin
      errors++;
      $display("FAIL fill_writes: %0d writes %0d bad, want %0d writes 0 bad",
               wa.size(), nb, exp_a.size());
    end
    reg_rd(4, rd);
    checks++;
    if (rd !== 64'h2) begin
      errors++; $display("FAIL fill_status: got %0h want 2", rd);
    end
  endtask

  task automatic test_errors();
    int st[3] = '{1199, 5, 5};
    int ln[3] = '{2, 0, 4};
    int ct[3] = '{1, 1, 3};
    logic [DW-1:0] rd;
    for (int i = 0; i < 3; i++) begin
      reg_wr(1, DW'(st[i]));
      reg_wr(2, DW'(ln[i]));
      clear_log();
      reg_wr(0, DW'(ct[i]));
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL err%0d_busy: got %b want 0", i, busy);
      end
      reg_rd(4, rd);
      checks++;
      if (rd !== 64'h4) begin
        errors++; $display("FAIL err%0d_status: got %0h want 4", i, rd);
      end
      repeat (4) tick();
      checks++;
      if (wa.size() != 0) begin
        errors++; $display("FAIL err%0d_writes: got %0d want 0", i, wa.size());
      end
    end
    reg_wr(1, DEPTH - 1);
    reg_wr(2, 1);
    clear_log();
    reg_wr(0, 1);
    wait_idle(50, "edge");
    checks++;
    if (wa.size() != 1 || wa[0] !== AW'(DEPTH - 1) ||
        wd[0] !== back_mem[DEPTH-1]) begin
      errors++;
      $display("FAIL edge_write: %0d writes, want 1 at %0d", wa.size(), DEPTH-1);
    end
    reg_rd(4, rd);
    checks++;
    if (rd !== 64'h2) begin
      errors++; $display("FAIL edge_status: got %0h want 2", rd);
    end
  endtask

  task automatic test_vblank();
    int nb;
    logic [DW-1:0] rd;
    vblank = 1'b0;
    reg_wr(1, 30);
    reg_wr(2, 8);
    clear_log();
    reg_wr(0, 5);
    repeat (20) tick();
    checks++;
    if (wa.size() != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL vb_hold: %0d writes busy %b, want 0 writes busy 1",
               wa.size(), busy);
    end
    vblank = 1'b1; repeat (3) tick();
    vblank = 1'b0; repeat (10) tick();
    vblank = 1'b1;
    wait_idle(100, "vb");
    vblank = 1'b0;
    model(30, 8, 1'b0, '0);
    nb = 0;
    foreach (exp_a[j])
      if (j >= wa.size() || wa[j] !== exp_a[j] || wd[j] !== exp_d[j]) nb++;
    checks++;
    if (wa.size() != exp_a.size() || nb != 0) begin
      errors++;
      $display("FAIL vb_writes: %0d writes %0d bad, want %0d writes 0 bad",
               wa.size(), nb, exp_a.size());
    end
    nb = 0;
    foreach (wv[j]) if (wv[j] !== 1'b1) nb++;
    checks++;
    if (nb != 0) begin
      errors++; $display("FAIL vb_gating: %0d ungated writes, want 0", nb);
    end
    reg_rd(4, rd);
    checks++;
    if (rd !== 64'h2) begin
      errors++; $display("FAIL vb_status: got %0h want 2", rd);
    end
    reg_wr(0, 0);
  endtask

  task automatic test_abort();
    int n, nb;
    logic [DW-1:0] rd;
    reg_wr(1, 0);
    reg_wr(2, 100);
    clear_log();
    reg_wr(0, 1);
    n = 0;
    while (wa.size() < 40 && n < 200) begin tick(); n++; end
    reg_wr(0, 8);
    wait_idle(20, "abort");
    nb = 0;
    foreach (wa[j]) if (wa[j] !== AW'(j) || wd[j] !== back_mem[j]) nb++;
    checks++;
    if (wa.size() < 40 || wa.size() > 41 || nb != 0) begin
      errors++;
      $display("FAIL abort_writes: %0d writes %0d bad, want 40..41 writes 0 bad",
               wa.size(), nb);
    end
    reg_rd(4, rd);
    checks++;
    if (rd !== 64'h8) begin
      errors++; $display("FAIL abort_status: got %0h want 8", rd);
    end
    reg_wr(1, 5);
    reg_rd(1, rd);
    checks++;
    if (rd !== 64'd5) begin
      errors++; $display("FAIL abort_start_wr: got %0h want 5", rd);
    end
  endtask

  task automatic test_busy_protect();
    int nb;
    logic [DW-1:0] rd, f;
    f = 64'h1234_5678_9ABC_DEF0;
    reg_wr(3, f);
    reg_wr(1, 100);
    reg_wr(2, 50);
    clear_log();
    reg_wr(0, 2);
    repeat (5) tick();
    reg_wr(1, 7);
    reg_wr(0, 2);
    reg_wr(3, 0);
    reg_wr(2, 3);
    reg_rd(1, rd);
    checks++;
    if (rd !== 64'd100) begin
      errors++; $display("FAIL busy_start: got %0h want 100", rd);
    end
    reg_rd(2, rd);
    checks++;
    if (rd !== 64'd50) begin
      errors++; $display("FAIL busy_length: got %0h want 50", rd);
    end
    wait_idle(200, "busy");
    model(100, 50, 1'b1, f);
    nb = 0;
    foreach (exp_a[j])
      if (j >= wa.size() || wa[j] !== exp_a[j] || wd[j] !== exp_d[j]) nb++;
    checks++;
    if (wa.size() != exp_a.size() || nb != 0) begin
      errors++;
      $display("FAIL busy_writes: %0d writes %0d bad, want %0d writes 0 bad",
               wa.size(), nb, exp_a.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd;
    reg_wr(1, 0);
    reg_wr(2, 100);
    reg_wr(0, 1);
    repeat (20) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (dst_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: we=%b busy=%b want 0 0", dst_we, busy);
    end
    reset = 1'b0;
    reg_rd(4, rd);
    checks++;
    if (rd !== 64'h0) begin
      errors++; $display("FAIL rst_status: got %0h want 0", rd);
    end
    reg_rd(1, rd);
    checks++;
    if (rd !== 64'h0) begin
      errors++; $display("FAIL rst_start: got %0h want 0", rd);
    end
  endtask

  task automatic test_random();
    int s, l, m, g, nb, n;
    logic [DW-1:0] f, rd;
    for (int it = 0; it < 8; it++) begin
      s = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(1, (DEPTH - s) < 64 ? DEPTH - s : 64);
      m = $urandom_range(0, 1);
      g = $urandom_range(0, 1);
      f = {$urandom, $urandom};
      for (int k = s; k < s + l; k++) back_mem[k] = {$urandom, $urandom};
      reg_wr(1, DW'(s));
      reg_wr(2, DW'(l));
      reg_wr(3, f);
      clear_log();
      reg_wr(0, DW'((m != 0 ? 2 : 1) | (g << 2)));
      n = 0;
      while (busy === 1'b1 && n < 3000) begin
        vblank = 1'($urandom_range(0, 1));
        tick(); n++;
      end
      vblank = 1'b0;
      checks++;
      if (n >= 3000) begin
        errors++; $display("FAIL rnd%0d_timeout: busy after %0d cycles", it, n);
      end
      model(s, l, m != 0, f);
      nb = 0;
      foreach (exp_a[j])
        if (j >= wa.size() || wa[j] !== exp_a[j] || wd[j] !== exp_d[j]) nb++;
      checks++;
      if (wa.size() != exp_a.size() || nb != 0) begin
        errors++;
        $display("FAIL rnd%0d_writes: %0d writes %0d bad, want %0d writes 0 bad",
                 it, wa.size(), nb, exp_a.size());
      end
      if (g != 0) begin
        nb = 0;
        foreach (wv[j]) if (wv[j] !== 1'b1) nb++;
        checks++;
        if (nb != 0) begin
          errors++; $display("FAIL rnd%0d_gating: %0d ungated, want 0", it, nb);
        end
      end
      reg_rd(4, rd);
      checks++;
      if (rd !== 64'h2) begin
        errors++; $display("FAIL rnd%0d_status: got %0h want 2", it, rd);
      end
      reg_wr(0, 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 2048; k++) back_mem[k] = '0;
    test_reset();
    test_copy();
    test_w1c();
    test_fill();
    test_errors();
    test_vblank();
    test_abort();
    test_busy_protect();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
